// File: rtl/positron_argmax_pkg.sv
// Shared posit helpers and the FSM state type for the output-layer argmax stage.
package positron_argmax_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } argmax_state_t;

  // NaR code for a posit of width w, right-aligned in 64 bits.
  function automatic logic [63:0] posit_nar(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

  // p is a right-aligned, zero-extended posit of width w.
  function automatic logic posit_is_nar(input logic [63:0] p, input int unsigned w);
    return (p << (64 - w)) == 64'h8000_0000_0000_0000;
  endfunction

endpackage

// File: rtl/positron_argmax_cmp_gt.sv
// Signed greater-than over posit words; two's-complement order equals posit order.
module positron_argmax_cmp_gt #(
  parameter int unsigned POSIT_WIDTH = 16
) (
  input  logic [POSIT_WIDTH-1:0] a_i,
  input  logic [POSIT_WIDTH-1:0] b_i,
  output logic                   gt_o
);

  assign gt_o = $signed(a_i) > $signed(b_i);

endmodule

// File: rtl/positron_argmax.sv
// Argmax over a framed stream of posit activations; one result beat per frame.
module positron_argmax
  import positron_argmax_pkg::*;
#(
  parameter int unsigned POSIT_WIDTH = 16,
  parameter int unsigned POSIT_ES    = 0,
  parameter int unsigned NB_CLASSES  = 10,
  localparam int unsigned IDX_WIDTH  = (NB_CLASSES > 1) ? $clog2(NB_CLASSES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rtr_o,
  input  logic                   rts_i,
  input  logic                   sow_i,
  input  logic                   eow_i,
  input  logic [POSIT_WIDTH-1:0] posit_i,
  input  logic                   rtr_i,
  output logic                   rts_o,
  output logic                   sow_o,
  output logic                   eow_o,
  output logic [POSIT_WIDTH-1:0] posit_o,
  output logic [IDX_WIDTH-1:0]   class_o,
  output logic                   err_o,
  output logic                   nar_o
);

  localparam int unsigned CNT_WIDTH = $clog2(NB_CLASSES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(NB_CLASSES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  if (NB_CLASSES < 1) begin : g_bad_nb
    $error("NB_CLASSES must be at least 1");
  end
  if (POSIT_ES >= POSIT_WIDTH) begin : g_bad_es
    $error("POSIT_ES must be smaller than POSIT_WIDTH");
  end

  argmax_state_t          state_q, state_d;
  logic [POSIT_WIDTH-1:0] best_q, best_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_after;
  logic                   err_q, err_d;
  logic                   nar_q, nar_d;
  logic                   beat, beat_nar, beat_gt;

  positron_argmax_cmp_gt #(
    .POSIT_WIDTH(POSIT_WIDTH)
  ) u_cmp_gt (
    .a_i (posit_i),
    .b_i (best_q),
    .gt_o(beat_gt)
  );

  assign beat     = rts_i & rtr_o;
  assign beat_nar = posit_is_nar(64'(posit_i), POSIT_WIDTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      best_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      nar_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      nar_q   <= nar_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    best_d    = best_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    nar_d     = nar_q;
    cnt_after = cnt_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (beat && sow_i) begin
          // A sow beat always restarts the frame, discarding any partial one.
          best_d  = posit_i;
          idx_d   = '0;
          cnt_d   = CNT_ONE;
          nar_d   = beat_nar;
          err_d   = eow_i && (NB_CLASSES != 1);
          state_d = eow_i ? HOLD : ACCUM;
        end else if (beat && (state_q == ACCUM)) begin
          if (cnt_q < CNT_FULL) begin
            if (beat_gt) begin
              best_d = posit_i;
              idx_d  = IDX_WIDTH'(cnt_q);
            end
            cnt_after = cnt_q + CNT_ONE;
          end else begin
            err_d = 1'b1;
          end
          cnt_d = cnt_after;
          nar_d = nar_q | beat_nar;
          if (eow_i) begin
            if (cnt_after != CNT_FULL) begin
              err_d = 1'b1;
            end
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (rtr_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rtr_o = 1'b0;
    rts_o = 1'b0;
    unique case (state_q)
      IDLE, ACCUM: rtr_o = ~rst;
      HOLD:        rts_o = 1'b1;
      default:     rtr_o = 1'b0;
    endcase
    sow_o   = rts_o;
    eow_o   = rts_o;
    posit_o = best_q;
    class_o = idx_q;
    err_o   = err_q;
    nar_o   = nar_q;
  end

endmodule

// File: tb/tb_positron_argmax.sv
// Directed-vector bench for positron_argmax with a frame-level reference model.
module tb_positron_argmax;

  localparam int unsigned PW = 16;
  localparam int unsigned NB = 10;
  localparam int unsigned IW = 4;
  localparam logic [PW-1:0] NAR = 16'h8000;

  logic          tb_clk = 1'b0;
  logic          tb_reset_n = 1'b0;
  logic          tb_rst;
  logic          rtr_o, rts_i, sow_i, eow_i, rtr_i;
  logic          rts_o, sow_o, eow_o, err_o, nar_o;
  logic [PW-1:0] posit_i, posit_o;
  logic [IW-1:0] class_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 tb_clk = ~tb_clk;
  assign tb_rst = ~tb_reset_n;

  positron_argmax #(
    .POSIT_WIDTH(PW),
    .POSIT_ES   (0),
    .NB_CLASSES (NB)
  ) dut (
    .clk    (tb_clk),
    .rst    (tb_rst),
    .rtr_o  (rtr_o),
    .rts_i  (rts_i),
    .sow_i  (sow_i),
    .eow_i  (eow_i),
    .posit_i(posit_i),
    .rtr_i  (rtr_i),
    .rts_o  (rts_o),
    .sow_o  (sow_o),
    .eow_o  (eow_o),
    .posit_o(posit_o),
    .class_o(class_o),
    .err_o  (err_o),
    .nar_o  (nar_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects accepted beats, then evaluates the whole frame at eow.
  logic [PW-1:0] m_frame[$];
  bit            m_in_frame = 0;
  bit            m_holding = 0;
  logic [PW-1:0] m_posit = '0;
  logic [IW-1:0] m_class = '0;
  logic          m_err = 1'b0;
  logic          m_nar = 1'b0;

  task automatic model_result();
    int n = m_frame.size();
    int lim = (n < NB) ? n : NB;
    logic signed [PW-1:0] best = m_frame[0];
    int bi = 0;
    bit nar = 0;
    for (int i = 1; i < lim; i++) begin
      if ($signed(m_frame[i]) > best) begin
        best = m_frame[i];
        bi = i;
      end
    end
    foreach (m_frame[i]) if (m_frame[i] == NAR) nar = 1;
    m_posit = best;
    m_class = bi[IW-1:0];
    m_err   = (n != NB);
    m_nar   = nar;
  endtask

  initial forever begin
    @(posedge tb_clk);
    if (tb_rst) begin
      m_frame.delete();
      m_in_frame = 0;
      m_holding  = 0;
    end else if (m_holding) begin
      if (rtr_i) m_holding = 0;
    end else if (rts_i) begin
      if (sow_i) begin
        m_frame.delete();
        m_in_frame = 1;
      end
      if (m_in_frame) begin
        m_frame.push_back(posit_i);
        if (eow_i) begin
          model_result();
          m_in_frame = 0;
          m_holding  = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge tb_clk);
    check("cyc_rtr_o", rtr_o, !m_holding && !tb_rst);
    check("cyc_rts_o", rts_o, m_holding && !tb_rst);
    check("cyc_sow_o", sow_o, m_holding && !tb_rst);
    check("cyc_eow_o", eow_o, m_holding && !tb_rst);
    if (m_holding && !tb_rst) begin
      check("cyc_posit_o", posit_o, m_posit);
      check("cyc_class_o", class_o, m_class);
      check("cyc_err_o", err_o, m_err);
      check("cyc_nar_o", nar_o, m_nar);
    end
  end

  logic [PW-1:0] fr[$];

  task automatic make(input logic [PW-1:0] fill, input int n);
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(fill);
  endtask

  task automatic send_beat(input logic [PW-1:0] p, input logic s, input logic e);
    rts_i = 1'b1; sow_i = s; eow_i = e; posit_i = p;
    @(posedge tb_clk); #1;
    rts_i = 1'b0; sow_i = 1'b0; eow_i = 1'b0;
  endtask

  task automatic send_frame();
    foreach (fr[i]) send_beat(fr[i], i == 0, i == fr.size() - 1);
  endtask

  // Called one cycle after the eow beat; checks the hand-computed result.
  task automatic result_check(input string name, input logic [IW-1:0] cls,
                              input logic [PW-1:0] val, input logic err, input logic nar);
    check({name, "_rts"}, rts_o, 1);
    check({name, "_class"}, class_o, cls);
    check({name, "_posit"}, posit_o, val);
    check({name, "_err"}, err_o, err);
    check({name, "_nar"}, nar_o, nar);
  endtask

  task automatic consume();
    @(posedge tb_clk); #1;
  endtask

  initial begin
    rts_i = 1'b0; sow_i = 1'b0; eow_i = 1'b0; posit_i = '0; rtr_i = 1'b1;
    repeat (2) @(posedge tb_clk);
    #1;
    check("rst_rtr", rtr_o, 0);
    check("rst_rts", rts_o, 0);
    check("rst_posit", posit_o, 0);
    check("rst_class", class_o, 0);
    check("rst_err", err_o, 0);
    check("rst_nar", nar_o, 0);
    tb_reset_n = 1'b1;
    consume();
    check("idle_rtr", rtr_o, 1);

    // Stray beat without sow in IDLE is dropped.
    send_beat(16'h7FFF, 1'b0, 1'b0);
    check("stray_rts", rts_o, 0);

    make(16'h0000, 10); fr[7] = 16'h6000;
    send_frame(); result_check("max7", 4'd7, 16'h6000, 1'b0, 1'b0); consume();

    make(16'hC000, 10); fr[2] = 16'h4000; fr[5] = 16'h4000;
    send_frame(); result_check("tie", 4'd2, 16'h4000, 1'b0, 1'b0); consume();

    make(16'hC000, 10); fr[0] = NAR; fr[3] = 16'hE000;
    send_frame(); result_check("narmix", 4'd3, 16'hE000, 1'b0, 1'b1); consume();

    make(NAR, 10);
    send_frame(); result_check("allnar", 4'd0, NAR, 1'b0, 1'b1); consume();

    make(16'h1000, 6); fr[4] = 16'h3000;
    send_frame(); result_check("short", 4'd4, 16'h3000, 1'b1, 1'b0); consume();

    make(16'h0000, 12); fr[4] = 16'h2000; fr[11] = 16'h7000;
    send_frame(); result_check("long", 4'd4, 16'h2000, 1'b1, 1'b0); consume();

    // Backpressure: result must hold and a sow offered during HOLD must be refused.
    rtr_i = 1'b0;
    make(16'h0000, 10); fr[1] = 16'h5000;
    send_frame(); result_check("bp", 4'd1, 16'h5000, 1'b0, 1'b0);
    rts_i = 1'b1; sow_i = 1'b1; posit_i = 16'h7FFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge tb_clk); #1;
      check("bp_hold_rts", rts_o, 1);
      check("bp_hold_rtr", rtr_o, 0);
      check("bp_hold_posit", posit_o, 16'h5000);
      check("bp_hold_class", class_o, 1);
    end
    rts_i = 1'b0; sow_i = 1'b0;
    rtr_i = 1'b1;
    consume();
    check("bp_rel_rts", rts_o, 0);
    check("bp_rel_rtr", rtr_o, 1);
    make(16'hF000, 10); fr[8] = 16'h0100;
    send_frame(); result_check("after_bp", 4'd8, 16'h0100, 1'b0, 1'b0); consume();

    // sow reasserted at beat 4 restarts the frame.
    send_beat(16'h0000, 1'b1, 1'b0);
    send_beat(16'h0000, 1'b0, 1'b0);
    send_beat(16'h7000, 1'b0, 1'b0);
    send_beat(16'h0000, 1'b0, 1'b0);
    check("abort_rts", rts_o, 0);
    make(16'h1000, 10); fr[6] = 16'h3000;
    send_frame(); result_check("resow", 4'd6, 16'h3000, 1'b0, 1'b0); consume();

    // Reset mid-frame loses the partial frame.
    send_beat(16'h0000, 1'b1, 1'b0);
    send_beat(16'h7000, 1'b0, 1'b0);
    send_beat(NAR, 1'b0, 1'b0);
    tb_reset_n = 1'b0;
    consume();
    check("midrst_posit", posit_o, 0);
    check("midrst_class", class_o, 0);
    check("midrst_nar", nar_o, 0);
    consume();
    tb_reset_n = 1'b1;
    consume();
    make(16'h0000, 10); fr[9] = 16'h2800;
    send_frame(); result_check("post_rst", 4'd9, 16'h2800, 1'b0, 1'b0); consume();

    repeat (3) @(posedge tb_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
